// File: rtl/link_pkg.sv
// Framing constants and types shared by the link transmitter and receiver.
// Header layout: {1'b1, vl, cr, zero pad}, sent MSB flit first.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } rx_state_t;

    function automatic int header_size(input int gate_width);
        return 1 + 2 * gate_width;
    endfunction

    function automatic int header_flits(input int flit_width, input int gate_width);
        return (header_size(gate_width) + flit_width - 1) / flit_width;
    endfunction

    function automatic int header_width(input int flit_width, input int gate_width);
        return header_flits(flit_width, gate_width) * flit_width;
    endfunction

    function automatic int header_zeros(input int flit_width, input int gate_width);
        return header_width(flit_width, gate_width) - header_size(gate_width);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/rx_unpacker.sv
// Maps the data slots of one link word onto gates: the k-th data flit of a frame
// belongs to the k-th set bit of vl.
module rx_unpacker #(
    parameter int FW = 8,
    parameter int GW = 4,
    parameter int GF = 2
) (
    input  logic [GW-1:0]                  i_vl,
    input  logic [$clog2(GW+1)-1:0]        i_ofs,
    input  logic [$clog2(GF+1)-1:0]        i_first,
    input  logic [$clog2(GF+1)-1:0]        i_cnt,
    input  logic [GF-1:0][FW-1:0]          i_slot,
    output logic [GW-1:0]                  o_we,
    output logic [GW-1:0][FW-1:0]          o_wd
);

    int rank;

    // i_ofs: frame-relative index of the first data flit in this word,
    // i_first/i_cnt: slot where those flits start and how many there are.
    always_comb begin
        o_we = '0;
        o_wd = '0;
        rank = 0;
        for (int g = 0; g < GW; g++) begin
            if (i_vl[g]) begin
                if (rank >= int'(i_ofs) && rank < int'(i_ofs) + int'(i_cnt)) begin
                    o_we[g] = 1'b1;
                    for (int s = 0; s < GF; s++) begin
                        if (s == int'(i_first) + rank - int'(i_ofs)) o_wd[g] = i_slot[s];
                    end
                end
                rank++;
            end
        end
    end

endmodule

// File: rtl/receiver.sv
// Link receiver: parses header/data flits out of each deserialized word and presents
// a completed frame to the gate array as a single registered event.
module receiver
    import link_pkg::*;
#(
    parameter int FLIT_WIDTH = 8,
    parameter int GATE_WIDTH = 4,
    parameter int GATE_FOLDS = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [FLIT_WIDTH*GATE_FOLDS-1:0] i_rx,
    output logic [FLIT_WIDTH-1:0]          o_dt [GATE_WIDTH],
    output logic [GATE_WIDTH-1:0]          o_vl,
    output logic [GATE_WIDTH-1:0]          o_cr,
    output logic                           o_frame,
    output logic                           o_err
);

    localparam int HF  = header_flits(FLIT_WIDTH, GATE_WIDTH);
    localparam int HW  = header_width(FLIT_WIDTH, GATE_WIDTH);
    localparam int HZ  = header_zeros(FLIT_WIDTH, GATE_WIDTH);
    localparam int CW  = $clog2(GATE_WIDTH + 1);
    localparam int SW  = $clog2(GATE_FOLDS + 1);
    localparam int HCW = $clog2(HF + 1);
    localparam logic [HW-1:0] PAD_MASK = (HW'(1) << HZ) - HW'(1);

    logic [GATE_FOLDS-1:0][FLIT_WIDTH-1:0] slot;

    rx_state_t                             state_q, state_d;
    logic [HCW-1:0]                        hcnt_q, hcnt_d;
    logic [HW-1:0]                         hdr_q, hdr_d;
    logic [CW-1:0]                         rem_q, rem_d;
    logic [CW-1:0]                         ofs_q, ofs_d;
    logic [GATE_WIDTH-1:0]                 fvl_q, fvl_d;
    logic [GATE_WIDTH-1:0]                 fcr_q, fcr_d;
    logic [GATE_WIDTH-1:0][FLIT_WIDTH-1:0] pend_q, pend_d;
    logic [GATE_WIDTH-1:0]                 pwe_q, pwe_d;
    logic [GATE_WIDTH-1:0][FLIT_WIDTH-1:0] dt_q, dt_d;
    logic [GATE_WIDTH-1:0]                 vl_q, vl_d;
    logic [GATE_WIDTH-1:0]                 cr_q, cr_d;
    logic                                  frame_q, frame_d;
    logic                                  err_q, err_d;

    // slot walk results
    rx_state_t                             p;
    logic                                  fin, done, err;
    logic [HCW-1:0]                        hc;
    logic [HW-1:0]                         hdr;
    logic [CW-1:0]                         rem;
    logic [GATE_WIDTH-1:0]                 vl, cr;
    logic [SW-1:0]                         dfirst, dcnt;

    logic [GATE_WIDTH-1:0]                 we, mwe;
    logic [GATE_WIDTH-1:0][FLIT_WIDTH-1:0] wd, md;

    for (genvar s = 0; s < GATE_FOLDS; s++) begin : g_slot
        assign slot[s] = i_rx[(GATE_FOLDS-s-1)*FLIT_WIDTH +: FLIT_WIDTH];
    end

    // Walk the slots of this word in order; fin marks that the frame (or an
    // IDLE-word decision) is settled and every later slot must be zero.
    always_comb begin
        p      = state_q;
        hc     = hcnt_q;
        hdr    = hdr_q;
        rem    = rem_q;
        vl     = fvl_q;
        cr     = fcr_q;
        fin    = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        dfirst = '0;
        dcnt   = '0;
        for (int s = 0; s < GATE_FOLDS; s++) begin
            if (fin) begin
                if (slot[s] != '0) err = 1'b1;
            end else if (p == IDLE && !slot[s][FLIT_WIDTH-1]) begin
                err = (i_rx != '0);
                fin = 1'b1;
            end else if (p == IDLE || p == HDR) begin
                hdr = HW'({hdr, slot[s]});
                hc  = hc + HCW'(1);
                p   = HDR;
                if (int'(hc) == HF) begin
                    vl = hdr[HW-2 -: GATE_WIDTH];
                    cr = hdr[HW-2-GATE_WIDTH -: GATE_WIDTH];
                    hc = '0;
                    // A dirty pad means we were not aligned to a real header: drop it.
                    if ((hdr & PAD_MASK) != '0) begin
                        err = 1'b1;
                        fin = 1'b1;
                        p   = IDLE;
                    end else begin
                        rem = CW'(popcount(32'(vl)));
                        p   = DATA;
                        if (rem == '0) begin
                            done = 1'b1;
                            fin  = 1'b1;
                            p    = IDLE;
                        end
                    end
                end
            end else begin
                if (dcnt == '0) dfirst = SW'(s);
                dcnt = dcnt + SW'(1);
                rem  = rem - CW'(1);
                if (rem == '0) begin
                    done = 1'b1;
                    fin  = 1'b1;
                    p    = IDLE;
                end
            end
        end
    end

    rx_unpacker #(
        .FW (FLIT_WIDTH),
        .GW (GATE_WIDTH),
        .GF (GATE_FOLDS)
    ) u_unpack (
        .i_vl    (vl),
        .i_ofs   (ofs_q),
        .i_first (dfirst),
        .i_cnt   (dcnt),
        .i_slot  (slot),
        .o_we    (we),
        .o_wd    (wd)
    );

    // Data of a frame spanning several words is staged so o_dt only ever shows
    // completed frames.
    always_comb begin
        state_d = p;
        hcnt_d  = hc;
        hdr_d   = hdr;
        rem_d   = (p == DATA) ? rem : '0;
        ofs_d   = (p == DATA) ? ofs_q + CW'(dcnt) : '0;
        fvl_d   = vl;
        fcr_d   = cr;
        mwe     = ((state_q == IDLE) ? '0 : pwe_q) | we;
        md      = pend_q;
        dt_d    = dt_q;
        for (int g = 0; g < GATE_WIDTH; g++) begin
            if (we[g]) md[g] = wd[g];
            if (done && mwe[g]) dt_d[g] = md[g];
        end
        pend_d  = md;
        pwe_d   = (p == IDLE) ? '0 : mwe;
        vl_d    = done ? vl : '0;
        cr_d    = done ? cr : '0;
        frame_d = done;
        err_d   = err;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            hdr_q   <= '0;
            rem_q   <= '0;
            ofs_q   <= '0;
            fvl_q   <= '0;
            fcr_q   <= '0;
            pend_q  <= '0;
            pwe_q   <= '0;
            dt_q    <= '0;
            vl_q    <= '0;
            cr_q    <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            hdr_q   <= hdr_d;
            rem_q   <= rem_d;
            ofs_q   <= ofs_d;
            fvl_q   <= fvl_d;
            fcr_q   <= fcr_d;
            pend_q  <= pend_d;
            pwe_q   <= pwe_d;
            dt_q    <= dt_d;
            vl_q    <= vl_d;
            cr_q    <= cr_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int g = 0; g < GATE_WIDTH; g++) o_dt[g] = dt_q[g];
    end

    assign o_vl    = vl_q;
    assign o_cr    = cr_q;
    assign o_frame = frame_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: a table of link words with hand-computed outputs,
// followed by a reset-during-frame sequence.
module tb_receiver;

    logic        clk;
    logic        rst;
    logic [15:0] rx;
    logic [7:0]  o_dt [4];
    logic [3:0]  o_vl;
    logic [3:0]  o_cr;
    logic        o_frame;
    logic        o_err;

    int n_cmp  = 0;
    int n_fail = 0;

    receiver #(
        .FLIT_WIDTH (8),
        .GATE_WIDTH (4),
        .GATE_FOLDS (2)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_rx    (rx),
        .o_dt    (o_dt),
        .o_vl    (o_vl),
        .o_cr    (o_cr),
        .o_frame (o_frame),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rx;
        logic        frame;
        logic        err;
        logic [3:0]  vl;
        logic [3:0]  cr;
        logic [31:0] dt;   // {gate3, gate2, gate1, gate0}
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic logic [31:0] dt_all();
        return {o_dt[3], o_dt[2], o_dt[1], o_dt[0]};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic frame, input logic err,
                             input logic [3:0] vl, input logic [3:0] cr, input logic [31:0] dt);
        check("o_frame", idx, 32'(o_frame), 32'(frame));
        check("o_err",   idx, 32'(o_err),   32'(err));
        check("o_vl",    idx, 32'(o_vl),    32'(vl));
        check("o_cr",    idx, 32'(o_cr),    32'(cr));
        check("o_dt",    idx, dt_all(),     dt);
    endtask

    initial begin
        // basic frame: vl=1010 cr=0011, data A1->g1, B3->g3
        vecs[0]  = '{16'hD180, 1'b0, 1'b0, 4'h0, 4'h0, 32'h00000000};
        vecs[1]  = '{16'hA1B3, 1'b1, 1'b0, 4'hA, 4'h3, 32'hB300A100};
        vecs[2]  = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB300A100};
        // three data flits across two words, last word half empty
        vecs[3]  = '{16'hB800, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB300A100};
        vecs[4]  = '{16'h1122, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB300A100};
        vecs[5]  = '{16'h3300, 1'b1, 1'b0, 4'h7, 4'h0, 32'hB3332211};
        // zero-valid frame, then back-to-back frames
        vecs[6]  = '{16'h8280, 1'b1, 1'b0, 4'h0, 4'h5, 32'hB3332211};
        vecs[7]  = '{16'h8F80, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB3332211};
        vecs[8]  = '{16'h5500, 1'b1, 1'b0, 4'h1, 4'hF, 32'hB3332255};
        vecs[9]  = '{16'hD180, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB3332255};
        vecs[10] = '{16'hA1B3, 1'b1, 1'b0, 4'hA, 4'h3, 32'hB333A155};
        // framing errors: no marker in IDLE, stray slot after last flit
        vecs[11] = '{16'h0080, 1'b0, 1'b1, 4'h0, 4'h0, 32'hB333A155};
        vecs[12] = '{16'h8F80, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB333A155};
        vecs[13] = '{16'h5566, 1'b1, 1'b1, 4'h1, 4'hF, 32'hB333A155};
        vecs[14] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB333A155};
        // marker-looking flit inside DATA is plain data
        vecs[15] = '{16'h9800, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB333A155};
        vecs[16] = '{16'h8F80, 1'b1, 1'b0, 4'h3, 4'h0, 32'hB333808F};
        vecs[17] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB333808F};

        rst = 1'b1;
        rx  = 16'h0000;
        #12;
        check_all(-1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rx = vecs[i].rx;
            @(negedge clk);
            check_all(i, vecs[i].frame, vecs[i].err, vecs[i].vl, vecs[i].cr, vecs[i].dt);
        end

        // reset in the middle of a frame discards it and clears every output
        rx = 16'hD180;
        @(negedge clk);
        check_all(100, 1'b0, 1'b0, 4'h0, 4'h0, 32'hB333808F);
        #2 rst = 1'b1;
        rx = 16'h0000;
        #1;
        check_all(101, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rx  = 16'hA1B3;
        @(negedge clk);
        check_all(102, 1'b0, 1'b1, 4'h0, 4'h0, 32'h0);
        rx = 16'h0000;
        @(negedge clk);
        check_all(103, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        // parser is back in sync after the reset
        rx = 16'h8F80;
        @(negedge clk);
        rx = 16'h7700;
        @(negedge clk);
        check_all(104, 1'b1, 1'b0, 4'h1, 4'hF, 32'h00000077);
        rx = 16'h0000;
        @(negedge clk);
        check_all(105, 1'b0, 1'b0, 4'h0, 4'h0, 32'h00000077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
